// File: rtl/bn128_pnt_scl_unpack_if.sv
// Valid/ready stream bundle with frame markers used by the BN128 point/scalar
// unpacker.
//   dat : payload, DAT_BITS wide
//   val : source holds a beat
//   rdy : sink takes the beat in a cycle where val and rdy are both 1
//   sop : first beat of a frame
//   eop : last beat of a frame
// The source and sink modports are the names the unpacker uses. The master and
// slave modports give the same two directions under their usual names.
interface bn128_pnt_scl_unpack_if #(
    parameter int DAT_BITS = 256
);
    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;

    modport source (output dat, output val, output sop, output eop, input rdy);
    modport sink   (input dat, input val, input sop, input eop, output rdy);
    modport master (output dat, output val, output sop, output eop, input rdy);
    modport slave  (input dat, input val, input sop, input eop, output rdy);
endinterface

// File: rtl/bn128_pnt_scl_unpack.sv
// Splits a serialized {scalar, x, y, z} frame into a scalar beat and a Jacobian
// point beat. Malformed frames are dropped and counted.
//
// Ports
//   i_clk, i_rst_n : rising-edge clock and asynchronous active-low reset
//   i_pnt_scl_if   : input frame stream (sink). Beat order is scalar (sop),
//                    x, y, z (eop).
//   o_scl_if       : recovered scalar, one beat per frame, sop = eop = 1
//   o_pnt_if       : recovered point {z, y, x}, 3*DAT_BITS wide, sop = eop = 1
//   o_frm_cnt      : frames emitted, wraps modulo 2^64
//   o_err_cnt      : framing errors, saturates at 16'hFFFF
//
// State table (beat counter)
//   BEAT_SCL | waiting for the sop beat that carries the scalar
//   BEAT_X   | scalar staged, waiting for x
//   BEAT_Y   | x staged, waiting for y
//   BEAT_Z   | y staged, waiting for z with eop. This beat is only taken when
//            | both output slots can accept a new beat.
module bn128_pnt_scl_unpack #(
    parameter int DAT_BITS  = 256,
    parameter int FRM_BEATS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    bn128_pnt_scl_unpack_if.sink          i_pnt_scl_if,
    bn128_pnt_scl_unpack_if.source        o_scl_if,
    bn128_pnt_scl_unpack_if.source        o_pnt_if,
    output logic [63:0]                   o_frm_cnt,
    output logic [15:0]                   o_err_cnt
);

    localparam int CNT_W = $clog2(FRM_BEATS);

    typedef enum logic [CNT_W-1:0] {
        BEAT_SCL = CNT_W'(0),
        BEAT_X   = CNT_W'(1),
        BEAT_Y   = CNT_W'(2),
        BEAT_Z   = CNT_W'(3)
    } beat_t;

    beat_t               cnt;
    logic [1:0]          rst_sync;
    logic [DAT_BITS-1:0] scl_r;
    logic [DAT_BITS-1:0] x_r;
    logic [DAT_BITS-1:0] y_r;

    logic                  scl_val;
    logic [DAT_BITS-1:0]   scl_dat;
    logic                  pnt_val;
    logic [3*DAT_BITS-1:0] pnt_dat;

    logic in_rdy;
    logic acc;
    logic err_sop;
    logic err_nosop;
    logic err_eop;
    logic err_noeop;
    logic bad;
    logic emit;
    logic scl_free;
    logic pnt_free;

    // Reset release goes through two flops, so rdy first rises on the second
    // clock edge after deassertion. Assertion still takes effect immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    // A slot is free if it is empty or is being drained this cycle. This lets
    // beat z land in the same cycle the previous result leaves. rdy depends
    // only on cnt and the output handshakes, never on the input val.
    always_comb begin
        scl_free = ~scl_val | o_scl_if.rdy;
        pnt_free = ~pnt_val | o_pnt_if.rdy;
        in_rdy   = rst_sync[1] & ((cnt != BEAT_Z) | (scl_free & pnt_free));
        acc      = i_pnt_scl_if.val & in_rdy;
    end

    // Framing checks. A stray sop has priority over every other error and
    // restarts the frame. That is why the other error terms are only looked at
    // when err_sop is clear.
    always_comb begin
        err_sop   = i_pnt_scl_if.sop & (cnt != BEAT_SCL);
        err_nosop = ~i_pnt_scl_if.sop & (cnt == BEAT_SCL);
        err_eop   = i_pnt_scl_if.eop & (cnt != BEAT_Z);
        err_noeop = ~i_pnt_scl_if.eop & (cnt == BEAT_Z);
        bad       = err_sop | err_nosop | err_eop | err_noeop;
        emit      = acc & ~bad & (cnt == BEAT_Z);
    end

    assign i_pnt_scl_if.rdy = in_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= BEAT_SCL;
            scl_val   <= 1'b0;
            pnt_val   <= 1'b0;
            o_frm_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            if (o_scl_if.rdy) begin
                scl_val <= 1'b0;
            end
            if (o_pnt_if.rdy) begin
                pnt_val <= 1'b0;
            end
            if (emit) begin
                scl_val   <= 1'b1;
                pnt_val   <= 1'b1;
                o_frm_cnt <= o_frm_cnt + 64'd1;
            end
            if (acc) begin
                if (bad && o_err_cnt != 16'hFFFF) begin
                    o_err_cnt <= o_err_cnt + 16'd1;
                end
                if (err_sop) begin
                    cnt <= BEAT_X;
                end else if (bad) begin
                    cnt <= BEAT_SCL;
                end else begin
                    case (cnt)
                        BEAT_SCL: cnt <= BEAT_X;
                        BEAT_X:   cnt <= BEAT_Y;
                        BEAT_Y:   cnt <= BEAT_Z;
                        default:  cnt <= BEAT_SCL;
                    endcase
                end
            end
        end
    end

    // Payload registers have no reset. The val flags above decide whether
    // their contents mean anything.
    always_ff @(posedge i_clk) begin
        if (acc && (err_sop || (cnt == BEAT_SCL && !bad))) begin
            scl_r <= i_pnt_scl_if.dat;
        end
        if (acc && !bad && cnt == BEAT_X) begin
            x_r <= i_pnt_scl_if.dat;
        end
        if (acc && !bad && cnt == BEAT_Y) begin
            y_r <= i_pnt_scl_if.dat;
        end
        if (emit) begin
            scl_dat <= scl_r;
            pnt_dat <= {i_pnt_scl_if.dat, y_r, x_r};
        end
    end

    assign o_scl_if.val = scl_val;
    assign o_scl_if.sop = scl_val;
    assign o_scl_if.eop = scl_val;
    assign o_scl_if.dat = scl_dat;
    assign o_pnt_if.val = pnt_val;
    assign o_pnt_if.sop = pnt_val;
    assign o_pnt_if.eop = pnt_val;
    assign o_pnt_if.dat = pnt_dat;

endmodule

// File: tb/tb_bn128_pnt_scl_unpack.sv
module tb_bn128_pnt_scl_unpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] frm_cnt;
    logic [15:0] err_cnt;

    bn128_pnt_scl_unpack_if #(.DAT_BITS(256)) in_if ();
    bn128_pnt_scl_unpack_if #(.DAT_BITS(256)) scl_if ();
    bn128_pnt_scl_unpack_if #(.DAT_BITS(768)) pnt_if ();

    bn128_pnt_scl_unpack #(.DAT_BITS(256), .FRM_BEATS(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pnt_scl_if (in_if.sink),
        .o_scl_if     (scl_if.source),
        .o_pnt_if     (pnt_if.source),
        .o_frm_cnt    (frm_cnt),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [255:0] scl_q [$];
    logic [767:0] pnt_q [$];

    always @(posedge clk) begin
        if (scl_if.val && scl_if.rdy) scl_q.push_back(scl_if.dat);
        if (pnt_if.val && pnt_if.rdy) pnt_q.push_back(pnt_if.dat);
    end

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat and hold it until accepted (bounded); returns edges used.
    task automatic beat(input logic [255:0] d, input logic s, input logic e, output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        in_if.dat = d;
        in_if.sop = s;
        in_if.eop = e;
        in_if.val = 1'b1;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = in_if.rdy;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ok) chk("beat_accept_timeout", {767'd0, ok}, 768'd1);
    endtask

    task automatic frame(input logic [255:0] s, input logic [255:0] x,
                         input logic [255:0] y, input logic [255:0] z, output int cyc);
        int c;
        cyc = 0;
        beat(s, 1'b1, 1'b0, c); cyc += c;
        beat(x, 1'b0, 1'b0, c); cyc += c;
        beat(y, 1'b0, 1'b0, c); cyc += c;
        beat(z, 1'b0, 1'b1, c); cyc += c;
    endtask

    task automatic idle();
        in_if.val = 1'b0;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
    endtask

    initial begin
        int c;
        int total;
        rst_n      = 1'b0;
        in_if.dat  = '0;
        idle();
        scl_if.rdy = 1'b1;
        pnt_if.rdy = 1'b1;

        // Reset state and synchronized release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", in_if.rdy, 0);
        chk("rst_scl_val", scl_if.val, 0);
        chk("rst_pnt_val", pnt_if.val, 0);
        chk("rst_frm", frm_cnt, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy_edge1", in_if.rdy, 0);
        @(posedge clk); #1;
        chk("rel_rdy_edge2", in_if.rdy, 1);

        // Nominal frame
        frame(256'd5, 256'd1, 256'd2, 256'd1, c);
        chk("nom_scl_val", scl_if.val, 1);
        chk("nom_scl_dat", scl_if.dat, 5);
        chk("nom_scl_sop_eop", {scl_if.sop, scl_if.eop}, 2'b11);
        chk("nom_pnt_val", pnt_if.val, 1);
        chk("nom_pnt_dat", pnt_if.dat, {256'd1, 256'd2, 256'd1});
        chk("nom_frm", frm_cnt, 1);
        chk("nom_err", err_cnt, 0);
        idle();
        @(posedge clk); #1;
        chk("nom_scl_drained", scl_if.val, 0);
        chk("nom_scl_q", scl_q.size(), 1);

        // Backpressure on the point output
        pnt_if.rdy = 1'b0;
        frame(256'd21, 256'd3, 256'd4, 256'd5, c);
        idle();
        repeat (10) @(posedge clk);
        #1;
        chk("bp_pnt_hold_val", pnt_if.val, 1);
        chk("bp_pnt_hold_dat", pnt_if.dat, {256'd5, 256'd4, 256'd3});
        beat(256'd11, 1'b1, 1'b0, c);
        beat(256'd12, 1'b0, 1'b0, c);
        beat(256'd13, 1'b0, 1'b0, c);
        in_if.dat = 256'd14;
        in_if.sop = 1'b0;
        in_if.eop = 1'b1;
        in_if.val = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_beat3_stall", in_if.rdy, 0);
        end
        @(posedge clk); #1;
        pnt_if.rdy = 1'b1;
        @(negedge clk);
        chk("bp_beat3_rdy", in_if.rdy, 1);
        @(posedge clk); #1;
        idle();
        chk("bp_pnt2_val", pnt_if.val, 1);
        chk("bp_pnt2_dat", pnt_if.dat, {256'd14, 256'd13, 256'd12});
        chk("bp_pnt_q_size", pnt_q.size(), 2);
        chk("bp_pnt_q_a", pnt_q[$], {256'd5, 256'd4, 256'd3});
        chk("bp_frm", frm_cnt, 3);
        @(posedge clk); #1;

        // Resync: sop arrives where beat2 of frame A was expected
        beat(256'd7, 1'b1, 1'b0, c);
        beat(256'd70, 1'b0, 1'b0, c);
        frame(256'd9, 256'd90, 256'd91, 256'd92, c);
        idle();
        @(posedge clk); #1;
        chk("rs_err", err_cnt, 1);
        chk("rs_frm", frm_cnt, 4);
        chk("rs_scl_q_size", scl_q.size(), 4);
        chk("rs_scl_last", scl_q[$], 9);
        chk("rs_pnt_last", pnt_q[$], {256'd92, 256'd91, 256'd90});

        // Missing eop on beat3, then a good frame
        beat(256'd13, 1'b1, 1'b0, c);
        beat(256'd130, 1'b0, 1'b0, c);
        beat(256'd131, 1'b0, 1'b0, c);
        beat(256'd132, 1'b0, 1'b0, c);
        frame(256'd15, 256'd150, 256'd151, 256'd152, c);
        idle();
        @(posedge clk); #1;
        chk("me_err", err_cnt, 2);
        chk("me_frm", frm_cnt, 5);
        chk("me_scl_q_size", scl_q.size(), 5);
        chk("me_scl_last", scl_q[$], 15);

        // No sop at cnt 0, sop+eop at cnt 0, eop at cnt 1
        beat(256'd33, 1'b0, 1'b0, c);
        beat(256'd34, 1'b1, 1'b1, c);
        beat(256'd35, 1'b1, 1'b0, c);
        beat(256'd36, 1'b0, 1'b1, c);
        idle();
        @(posedge clk); #1;
        chk("ef_err", err_cnt, 5);
        chk("ef_frm", frm_cnt, 5);
        chk("ef_scl_q_size", scl_q.size(), 5);

        // Throughput: 100 frames, val held high
        total = 0;
        for (int i = 0; i < 100; i++) begin
            frame(256'(1000 + i), 256'(2000 + i), 256'(3000 + i), 256'(4000 + i), c);
            total += c;
        end
        idle();
        @(posedge clk); #1;
        chk("tp_cycles", total, 400);
        chk("tp_frm", frm_cnt, 105);
        chk("tp_err", err_cnt, 5);
        chk("tp_scl_q_size", scl_q.size(), 105);
        chk("tp_scl_last", scl_q[$], 1099);
        chk("tp_pnt_last", pnt_q[$], {256'd4099, 256'd3099, 256'd2099});

        // Reset pulsed during beat1
        beat(256'd40, 1'b1, 1'b0, c);
        in_if.dat = 256'd41;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
        in_if.val = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mr_rdy", in_if.rdy, 0);
        chk("mr_scl_val", scl_if.val, 0);
        chk("mr_pnt_val", pnt_if.val, 0);
        chk("mr_frm", frm_cnt, 0);
        chk("mr_err", err_cnt, 0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        frame(256'd50, 256'd51, 256'd52, 256'd53, c);
        chk("mr_post_scl", scl_if.dat, 50);
        chk("mr_post_pnt", pnt_if.dat, {256'd53, 256'd52, 256'd51});
        chk("mr_post_frm", frm_cnt, 1);
        chk("mr_post_err", err_cnt, 0);
        idle();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
